// File: rtl/part2b.sv
// Register file of four general (R1..R4) and four temporary (T1..T4) registers,
// each with per-register decrement/increment/load/clear and two read muxes.
module part2b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       funsel,
  input  logic [3:0]       Rsel,
  input  logic [3:0]       Tsel,
  input  logic [2:0]       O1sel,
  input  logic [2:0]       O2sel,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2
);

  typedef enum logic [1:0] {
    FN_DEC  = 2'b00,
    FN_INC  = 2'b01,
    FN_LOAD = 2'b10,
    FN_CLR  = 2'b11
  } fun_e;

  // Bank ordered to match the read-select encoding: 0..3 = T1..T4, 4..7 = R1..R4.
  logic [WIDTH-1:0] bank [8];
  logic [7:0]       en;

  // Select masks are MSB-first (bit3 = R1/T1), so reverse them into bank order.
  assign en = {Rsel[0], Rsel[1], Rsel[2], Rsel[3],
               Tsel[0], Tsel[1], Tsel[2], Tsel[3]};

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] res;
    // NOTE: res is given a value on every path (default arm), so no latch is inferred.
    case (fun_e'(op))
      FN_DEC:  res = cur - WIDTH'(1);
      FN_INC:  res = cur + WIDTH'(1);
      FN_LOAD: res = din;
      FN_CLR:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // NOTE: the bank is a small flop array, so every entry is reset rather than left
  // unreset like an inferred RAM; state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (en[i]) bank[i] <= apply_op(funsel, bank[i], data_in);
      end
    end
  end

  assign O1 = bank[O1sel];
  assign O2 = bank[O2sel];

endmodule

// File: tb/tb_part2b.sv
// Directed bench for part2b: drives operations on the falling edge and reads
// all eight registers back through both output muxes after each rising edge.
module tb_part2b;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       funsel;
  logic [3:0]       Rsel;
  logic [3:0]       Tsel;
  logic [2:0]       O1sel;
  logic [2:0]       O2sel;
  logic [WIDTH-1:0] O1;
  logic [WIDTH-1:0] O2;

  int checks   = 0;
  int failures = 0;

  // Expected contents in read-select order: T1, T2, T3, T4, R1, R2, R3, R4.
  logic [WIDTH-1:0] exp_v [8];

  part2b #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .funsel  (funsel),
    .Rsel    (Rsel),
    .Tsel    (Tsel),
    .O1sel   (O1sel),
    .O2sel   (O2sel),
    .O1      (O1),
    .O2      (O2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] actual,
                       input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] fun,
                      input logic [WIDTH-1:0] din, input logic [3:0] rs,
                      input logic [3:0] ts);
    @(negedge clk);
    rst_n   = rst;
    funsel  = fun;
    data_in = din;
    Rsel    = rs;
    Tsel    = ts;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    Rsel  = 4'b0000;
    Tsel  = 4'b0000;
  endtask

  task automatic check_regs(input string tag);
    for (int s = 0; s < 8; s++) begin
      O1sel = 3'(s);
      O2sel = 3'(7 - s);
      #1;
      check($sformatf("%s O1sel=%0d", tag, s), O1, exp_v[s]);
      check($sformatf("%s O2sel=%0d", tag, 7 - s), O2, exp_v[7 - s]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = '0;
    funsel  = 2'b00;
    Rsel    = 4'b0000;
    Tsel    = 4'b0000;
    O1sel   = 3'd0;
    O2sel   = 3'd0;

    // Reset with a competing load pending: reset wins.
    step(1'b0, 2'b10, 8'd25, 4'b1111, 4'b1111);
    exp_v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_regs("reset");

    step(1'b1, 2'b10, 8'd18, 4'b1111, 4'b1111);
    exp_v = '{8'd18, 8'd18, 8'd18, 8'd18, 8'd18, 8'd18, 8'd18, 8'd18};
    check_regs("load_all");

    step(1'b1, 2'b01, 8'd0, 4'b0101, 4'b0100);
    exp_v = '{8'd18, 8'd19, 8'd18, 8'd18, 8'd18, 8'd19, 8'd18, 8'd19};
    check_regs("sel_inc");

    step(1'b1, 2'b11, 8'd0, 4'b0001, 4'b1000);
    exp_v = '{8'd0, 8'd19, 8'd18, 8'd18, 8'd18, 8'd19, 8'd18, 8'd0};
    check_regs("sel_clr");

    // Both outputs pointed at the same register.
    O1sel = 3'd5;
    O2sel = 3'd5;
    #1;
    check("same_sel O1", O1, 8'd19);
    check("same_sel O2", O2, 8'd19);

    // No select bits: every funsel must leave the bank untouched.
    step(1'b1, 2'b10, 8'd99, 4'b0000, 4'b0000);
    step(1'b1, 2'b11, 8'd99, 4'b0000, 4'b0000);
    step(1'b1, 2'b00, 8'd99, 4'b0000, 4'b0000);
    check_regs("hold");

    step(1'b0, 2'b10, 8'd25, 4'b1111, 4'b1111);
    exp_v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_regs("reset_prio");

    step(1'b1, 2'b00, 8'd0, 4'b1000, 4'b0000);
    exp_v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0};
    check_regs("dec_wrap");

    step(1'b1, 2'b10, 8'd255, 4'b1000, 4'b0000);
    step(1'b1, 2'b01, 8'd0, 4'b1000, 4'b0000);
    exp_v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_regs("inc_wrap");

    step(1'b1, 2'b10, 8'h5A, 4'b0010, 4'b0001);
    exp_v = '{8'd0, 8'd0, 8'd0, 8'h5A, 8'd0, 8'd0, 8'h5A, 8'd0};
    check_regs("mixed_load");

    step(1'b1, 2'b00, 8'd0, 4'b0011, 4'b0011);
    exp_v = '{8'd0, 8'd0, 8'hFF, 8'h59, 8'd0, 8'd0, 8'h59, 8'hFF};
    check_regs("mixed_dec");

    // Inputs set up without a clock edge must not reach the outputs.
    @(negedge clk);
    funsel  = 2'b10;
    data_in = 8'hC3;
    Rsel    = 4'b1111;
    Tsel    = 4'b1111;
    O1sel   = 3'd4;
    O2sel   = 3'd0;
    #1;
    check("no_bypass O1", O1, 8'd0);
    check("no_bypass O2", O2, 8'd0);
    @(posedge clk);
    #1;
    check("after_edge O1", O1, 8'hC3);
    check("after_edge O2", O2, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
